// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift blocks: default widths, FSM encoding
// and the per-stage shift amount helper.
package alu_shift_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    function automatic int unsigned stage_amount(input int unsigned stage);
        return 32'd1 << stage;
    endfunction

endpackage

// File: rtl/right_shift_stage.sv
// One power-of-two right-shift stage: shifts by 2^stage_i with the given fill
// bit when enabled, otherwise passes the value through.
module right_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic [DATA_W-1:0]  value_i,
    input  logic               enable_i,
    input  logic [SHAMT_W-1:0] stage_i,
    input  logic               fill_i,
    output logic [DATA_W-1:0]  shifted_o
);

    logic [2*DATA_W-1:0] ext;
    logic [2*DATA_W-1:0] ext_shifted;

    // Prepending a full word of fill bits lets a plain logical shift supply
    // exactly the bits that enter from above the MSB.
    assign ext         = {{DATA_W{fill_i}}, value_i};
    assign ext_shifted = ext >> stage_amount(32'(stage_i));
    assign shifted_o   = enable_i ? ext_shifted[DATA_W-1:0] : value_i;

endmodule

// File: rtl/multicycle_right_shifter.sv
// Iterative srl/sra unit, one power-of-two stage per clock (MSB stage first).
// Define RSHIFT_EARLY_EXIT_EN to finish as soon as the remaining shamt bits are zero.
//
// state | meaning
// IDLE  | waiting for start, result holds the last value
// SHIFT | applying stage stage_q of the captured shift amount
// DONE  | one-cycle done pulse; a start here is accepted immediately
module multicycle_right_shifter
    import alu_shift_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
);

    localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

    shift_state_e       state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               arith_q, arith_d;
    logic [SHAMT_W-1:0] stage_q, stage_d;
    logic [DATA_W-1:0]  stage_out;
    logic               last_stage;

    // The working MSB keeps the original sign under sra, so it is the fill bit.
    right_shift_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .value_i   (work_q),
        .enable_i  (shamt_q[stage_q]),
        .stage_i   (stage_q),
        .fill_i    (arith_q & work_q[DATA_W-1]),
        .shifted_o (stage_out)
    );

`ifdef RSHIFT_EARLY_EXIT_EN
    logic [SHAMT_W-1:0] low_mask;
    assign low_mask   = (SHAMT_W'(1) << stage_q) - SHAMT_W'(1);
    assign last_stage = ((shamt_q & low_mask) == '0);
`else
    assign last_stage = (stage_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        shamt_d = shamt_q;
        arith_d = arith_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_d  = data_in;
                    shamt_d = shamt;
                    arith_d = arith;
                    stage_d = LAST_STAGE;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = stage_out;
                if (last_stage) begin
                    state_d = ST_DONE;
                end else begin
                    stage_d = stage_q - SHAMT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            shamt_q <= '0;
            arith_q <= 1'b0;
            stage_q <= LAST_STAGE;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            arith_q <= arith_d;
            stage_q <= stage_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign result = work_q;

endmodule

// File: tb/tb_multicycle_right_shifter.sv
// Self-checking bench for multicycle_right_shifter against an arithmetic
// reference model; honours RSHIFT_EARLY_EXIT_EN for expected latency.
module tb_multicycle_right_shifter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    multicycle_right_shifter #(
        .DATA_W  (32),
        .SHAMT_W (5)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic ar);
        logic signed [31:0] s;
        s = d;
        if (ar) return 32'(s >>> sh);
        return d >> sh;
    endfunction

    function automatic int exp_lat(input logic [4:0] sh);
`ifdef RSHIFT_EARLY_EXIT_EN
        int tz;
        if (sh == 5'd0) return 1;
        tz = 0;
        while (sh[tz] == 1'b0) tz++;
        return 5 - tz;
`else
        return 5 + 0 * int'(sh);
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one start for a single edge; leaves the DUT just after acceptance.
    task automatic start_op(input logic [31:0] d, input logic [4:0] sh, input logic ar);
        start   = 1'b1;
        data_in = d;
        shamt   = sh;
        arith   = ar;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after acceptance until done, plus cycles spent busy.
    task automatic wait_done(output int n, output int busy_cycles);
        n = 0;
        busy_cycles = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            tick();
            n++;
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] d, input logic [4:0] sh,
                            input logic ar);
        int n, bc;
        logic [31:0] exp;
        exp = ref_shift(d, sh, ar);
        start_op(d, sh, ar);
        wait_done(n, bc);
        checks++;
        if (n !== exp_lat(sh)) begin
            errors++;
            $display("FAIL %s latency got %0d expected %0d", name, n, exp_lat(sh));
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result got %h expected %h", name, result, exp);
        end
        checks++;
        if (bc !== exp_lat(sh) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy cycles got %0d (busy at done %b) expected %0d", name, bc,
                     busy, exp_lat(sh));
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse width got done=%b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        arith   = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b result=%h expected 0 0 0", busy,
                     done, result);
        end
        start   = 1'b1;
        data_in = 32'hDEAD_BEEF;
        shamt   = 5'd3;
        tick();
        checks++;
        if (busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_wins got busy=%b result=%h expected 0 0", busy, result);
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_logical();
        check_op("logical", 32'h8000_00F0, 5'd4, 1'b0);
    endtask

    task automatic test_arith();
        check_op("sra31", 32'h8000_0000, 5'd31, 1'b1);
        check_op("srl31", 32'h8000_0000, 5'd31, 1'b0);
        check_op("sra_mixed", 32'hF0F0_1234, 5'd7, 1'b1);
    endtask

    task automatic test_zero_amount();
        check_op("zero", 32'h1234_5678, 5'd0, 1'b1);
        check_op("shamt16", 32'h1234_5678, 5'd16, 1'b0);
        check_op("shamt1", 32'h8234_5678, 5'd1, 1'b1);
    endtask

    task automatic test_hold_start();
        int n, bc;
        start_op(32'hA5A5_0F0F, 5'd1, 1'b0);
        start   = 1'b1;
        data_in = 32'h1111_2222;
        shamt   = 5'd9;
        arith   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        start = 1'b0;
        wait_done(n, bc);
        checks++;
        if (result !== 32'h52D2_8787 || n !== 1) begin
            errors++;
            $display("FAIL hold_start got result=%h edges=%0d expected 52d28787 1", result, n);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_start_idle got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int n, bc;
        start_op(32'h0000_0100, 5'd8, 1'b0);
        wait_done(n, bc);
        checks++;
        if (done !== 1'b1 || result !== 32'h0000_0001) begin
            errors++;
            $display("FAIL b2b_first got done=%b result=%h expected 1 00000001", done, result);
        end
        start_op(32'hFFFF_0000, 5'd16, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b expected 1", busy);
        end
        wait_done(n, bc);
        checks++;
        if (result !== 32'h0000_FFFF || n !== exp_lat(5'd16)) begin
            errors++;
            $display("FAIL b2b_second got result=%h edges=%0d expected 0000ffff %0d", result, n,
                     exp_lat(5'd16));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        start_op(32'hCAFE_F00D, 5'd1, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b result=%h expected 0 0 0", busy, done,
                     result);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet got activity=%b expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [4:0]  sh;
        logic        ar;
        int          n, bc;
        d  = $urandom;
        sh = 5'($urandom_range(31));
        ar = 1'($urandom_range(1));
        start_op(d, sh, ar);
        for (int i = 0; i < 1000; i++) begin
            wait_done(n, bc);
            checks++;
            if (result !== ref_shift(d, sh, ar) || n !== exp_lat(sh)) begin
                errors++;
                $display("FAIL random[%0d] d=%h sh=%0d ar=%b got result=%h edges=%0d expected %h %0d",
                         i, d, sh, ar, result, n, ref_shift(d, sh, ar), exp_lat(sh));
            end
            d  = $urandom;
            sh = 5'($urandom_range(31));
            ar = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) begin
                start_op(d, sh, ar);
            end else begin
                tick();
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL random_pulse[%0d] got done=%b expected 0", i, done);
                end
                if (i != 999) start_op(d, sh, ar);
            end
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_zero_amount();
        test_hold_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_right_shifter.md
Name: multicycle_right_shifter

Overview:
- Iterative 32-bit right shifter for the ALU's srl/sra operations; the counterpart of the fixed left-shift stages.
- Applies one power-of-two stage per clock: 16, 8, 4, 2, 1.
- Has a start/done handshake so the ALU control can stall on it.
- Trades the area of a full barrel shifter for a 5-cycle latency.

Parameters:
- DATA_W, 32, operand/result width (power of two)
- SHAMT_W, 5, shift-amount width; equals log2(DATA_W) and sets the number of stages

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when accepting (IDLE or DONE)
- data_in  input  DATA_W  operand captured on accepted start
- shamt  input  SHAMT_W  shift amount captured on accepted start
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; result valid from this cycle
- result  output  DATA_W  shifted value; held until next accepted start

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, on port `reset`.
- Reset values: state = IDLE; result = 0; done = 0; busy = 0; internal stage counter = SHAMT_W-1. Reset wins over start in the same cycle.
- Reset mid-operation: an in-flight operation is discarded, with no done pulse.
- State IDLE:
  - start=1 at edge E: capture data_in into the working register (also driven on result), plus shamt and arith.
  - stage := SHAMT_W-1; go to SHIFT.
- State SHIFT, each edge:
  - If captured shamt[stage]=1, working := working >> 2^stage, filled with sign bit (arith=1) or 0.
  - If stage==0, go to DONE; else stage--.
- State DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE and goes straight to SHIFT (back-to-back operations). Otherwise go to IDLE.
- Latency (base build): start accepted at edge E, done=1 in the cycle after edge E+5. This holds for every shamt, including 0.
- Throughput: one operation per 6 cycles.
- start while busy is ignored; inputs during SHIFT have no effect.
- busy=1 exactly in SHIFT.
- result during SHIFT shows partial values; consumers sample only on done.
- Sign fill uses the captured arith and the original sign bit. Repeated sra stages preserve the sign, so a negative input shifted by 31 gives all-ones.
- All shifts are exact width; no bit enters from above the MSB other than the fill bit.

Optional Feature:
- Macro: RSHIFT_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, after applying the current stage, if captured shamt bits below stage are all zero (or stage==0), go to DONE.
  - In IDLE/DONE, on an accepted start with shamt=0, go to SHIFT as usual; the first SHIFT edge then exits.
  - Latency = SHAMT_W - tz(shamt) edges, where tz = trailing zeros; shamt=0 → 1 edge.
  - Examples: shamt=16 → 1, shamt=8 → 2, shamt=1 → 5.
- Undefined: fixed 5-edge latency as above.
- Result values are identical in both builds.

Decomposition:
- Shared package (alu_shift_pkg):
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - DATA_W/SHAMT_W defaults.
  - Stage-amount function 2^stage.
- One natural sub-module: right_shift_stage. Combinational; inputs are value, enable, stage index and fill bit; output is the value shifted by 2^stage when enabled, else passthrough.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Logical shift: reset, start with data_in=32'h8000_00F0, shamt=4, arith=0 → done exactly 5 edges after start; result=32'h0800_000F; busy high for 5 cycles.
- Arithmetic shift: data_in=32'h8000_0000, shamt=31, arith=1 → result=32'hFFFF_FFFF. Same operand with arith=0 → 32'h0000_0001.
- Zero amount: shamt=0, data_in=32'h1234_5678 → result unchanged.
  - Base build: done after 5 edges.
  - With RSHIFT_EARLY_EXIT_EN: done after 1 edge.
  - Also check shamt=16 → 1 edge and shamt=1 → 5 edges.
- Handshake:
  - start held high during SHIFT with different data → ignored; first result correct.
  - start=1 in the DONE cycle with data_in=32'hFFFF_0000, shamt=16, arith=0 → accepted; next done gives 32'h0000_FFFF.
- Reset mid-operation: assert reset on the 3rd SHIFT cycle → next cycle state IDLE, busy=0, done=0, result=0; no done pulse follows.
- Random sweep: 1000 random data/shamt/arith values → result matches the reference model `>>` / `>>>`; done pulses once per op, never two consecutive cycles without a new start.
